// File: rtl/cnn_acc_pkg.sv
// Shared types, default widths and the reference requantizer for the conv MAC accumulator.
package cnn_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int KERNEL_LEN_DEF = 9;
  localparam int PROD_W_DEF     = 16;
  localparam int ACC_W_DEF      = 24;
  localparam int OUT_W_DEF      = 8;
  localparam int SHIFT_DEF      = 7;

  localparam logic signed [ACC_W_DEF:0] OUT_MAX_DEF = (ACC_W_DEF+1)'(2**(OUT_W_DEF-1) - 1);
  localparam logic signed [ACC_W_DEF:0] OUT_MIN_DEF = (ACC_W_DEF+1)'(-(2**(OUT_W_DEF-1)));

  // Round half up, arithmetic shift and saturate, computed one bit wider than the
  // accumulator so the rounding constant can never overflow.
  function automatic logic signed [OUT_W_DEF-1:0] sat_requant(
    input logic signed [ACC_W_DEF-1:0] x,
    input int unsigned                 shift
  );
    logic signed [ACC_W_DEF:0] xe;
    logic signed [ACC_W_DEF:0] sh;
    xe = $signed({x[ACC_W_DEF-1], x}) + ((ACC_W_DEF+1)'(1) << (shift - 1));
    sh = xe >>> shift;
    if (sh > OUT_MAX_DEF) begin
      return OUT_W_DEF'(OUT_MAX_DEF);
    end else if (sh < OUT_MIN_DEF) begin
      return OUT_W_DEF'(OUT_MIN_DEF);
    end
    return OUT_W_DEF'(sh);
  endfunction

endpackage

// File: rtl/conv_mac_accumulator_if.sv
// Product-in / activation-out stream bundle for conv_mac_accumulator.
interface conv_mac_accumulator_if
  import cnn_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) ();

  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  bias;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     err_len;

  // Upstream multiplier array plus downstream activation buffer.
  modport master (
    output prod_valid, prod_data, prod_last, bias, out_ready,
    input  prod_ready, out_valid, out_data, out_sum, err_len
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, bias, out_ready,
    output prod_ready, out_valid, out_data, out_sum, err_len
  );

endinterface

// File: rtl/conv_mac_accumulator_requant_sat.sv
// Combinational requantizer: round half up, arithmetic right shift, saturate,
// optional ReLU when CONV_MAC_ACCUMULATOR_RELU_EN is defined.
module requant_sat
  import cnn_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] x,
  output logic signed [OUT_W-1:0] y
);

  logic signed [OUT_W-1:0] y_sat;

  generate
    if (ACC_W == ACC_W_DEF && OUT_W == OUT_W_DEF) begin : g_default
      always_comb begin
        y_sat = sat_requant(x, SHIFT);
      end
    end else begin : g_generic
      localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2**(SHIFT-1));
      localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
      localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

      logic signed [ACC_W:0] xe;
      logic signed [ACC_W:0] sh;

      always_comb begin
        xe = $signed({x[ACC_W-1], x}) + RND;
        sh = xe >>> SHIFT;
        if (sh > SAT_MAX) begin
          y_sat = OUT_W'(SAT_MAX);
        end else if (sh < SAT_MIN) begin
          y_sat = OUT_W'(SAT_MIN);
        end else begin
          y_sat = OUT_W'(sh);
        end
      end
    end
  endgenerate

`ifdef CONV_MAC_ACCUMULATOR_RELU_EN
  assign y = y_sat[OUT_W-1] ? '0 : y_sat;
`else
  assign y = y_sat;
`endif

endmodule

// File: rtl/conv_mac_accumulator.sv
// Sums one KERNEL_LEN-tap window of signed products plus bias and emits a requantized
// activation; ReLU on out_data is enabled by CONV_MAC_ACCUMULATOR_RELU_EN.
module conv_mac_accumulator
  import cnn_acc_pkg::*;
#(
  parameter int KERNEL_LEN = KERNEL_LEN_DEF,
  parameter int PROD_W     = PROD_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SHIFT      = SHIFT_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_mac_accumulator_if.slave bus
);

  localparam int               CNT_W    = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_LEN - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [OUT_W-1:0] quant_nxt;
  logic signed [OUT_W-1:0] out_data_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic                    err_len_q;
  logic                    ready_st;
  logic                    valid_st;
  logic                    accept;
  logic                    at_last;
  logic                    win_end;
  logic                    len_err;

  assign accept  = bus.prod_valid & bus.prod_ready;
  assign at_last = (count == LAST_CNT);
  assign win_end = accept & (at_last | bus.prod_last);
  // A window closed by the counter without prod_last, or by prod_last early, is a mismatch.
  assign len_err = win_end & (at_last ^ bus.prod_last);

  // The first beat of a window seeds the sum with the bias instead of the stale total.
  assign acc_base = (count == '0) ? bus.bias : acc;
  assign acc_nxt  = acc_base + ACC_W'(bus.prod_data);

  requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .x (acc_nxt),
    .y (quant_nxt)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ready_st  = 1'b0;
    valid_st  = 1'b0;
    unique case (state)
      ACC: begin
        ready_st = 1'b1;
        if (win_end) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        valid_st = 1'b1;
        if (bus.out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      count      <= '0;
      // NOTE: acc is reset even though count==0 masks it, so a partial sum never survives reset.
      acc        <= '0;
      out_data_q <= '0;
      out_sum_q  <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_len_q <= len_err;
      if (accept) begin
        acc   <= acc_nxt;
        count <= win_end ? '0 : count + 1'b1;
      end
      if (win_end) begin
        out_sum_q  <= acc_nxt;
        out_data_q <= quant_nxt;
      end
    end
  end

  assign bus.prod_ready = ready_st & rst_n;
  assign bus.out_valid  = valid_st;
  assign bus.out_data   = out_data_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.err_len    = err_len_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Directed self-checking bench for conv_mac_accumulator at default parameters.
module tb_conv_mac_accumulator;
  import cnn_acc_pkg::*;

`ifdef CONV_MAC_ACCUMULATOR_RELU_EN
  localparam logic signed [7:0] NEG_SAT = 8'sd0;
`else
  localparam logic signed [7:0] NEG_SAT = -8'sd128;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  conv_mac_accumulator_if #(.PROD_W(16), .ACC_W(24), .OUT_W(8)) bus ();

  conv_mac_accumulator #(
    .KERNEL_LEN (9),
    .PROD_W     (16),
    .ACC_W      (24),
    .OUT_W      (8),
    .SHIFT      (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic send_beat(input logic signed [15:0] d, input logic last,
                           input logic signed [23:0] b);
    int t;
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    bus.prod_last  = last;
    bus.bias       = b;
    t = 0;
    while (bus.prod_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL beat_accept: prod_ready=%b required 1 within 50 cycles", bus.prod_ready);
    end
    @(posedge clk);
    #1;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    bus.prod_data  = 16'sh7fff;
    bus.bias       = 24'sh3fffff;
  endtask

  // Beats are start + i*step; bias is only meaningful on the first beat, so later beats carry junk.
  task automatic run_window(input int n, input int start, input int step,
                            input logic signed [23:0] b, input bit last_on_end);
    for (int i = 0; i < n; i++) begin
      send_beat(16'(start + i * step), (last_on_end && i == n - 1), (i == 0) ? b : 24'sd999);
      if (i == n - 2) begin
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: out_valid=%b required 0 before final beat", bus.out_valid);
        end
      end
    end
  endtask

  task automatic take_result(input string name, input logic signed [23:0] es,
                             input logic signed [7:0] ed, input logic ee);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== es || bus.out_data !== ed || bus.err_len !== ee) begin
      n_fail++;
      $display("FAIL %s: valid=%b sum=%0d data=%0d err=%b required valid=1 sum=%0d data=%0d err=%b",
               name, bus.out_valid, bus.out_sum, bus.out_data, bus.err_len, es, ed, ee);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.err_len !== 1'b0 || bus.prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: valid=%b err=%b ready=%b required 0 0 1",
               name, bus.out_valid, bus.err_len, bus.prod_ready);
    end
  endtask

  task automatic test_reset();
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.prod_last  = 1'b0;
    bus.bias       = '0;
    bus.out_ready  = 1'b0;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (bus.prod_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 ||
        bus.out_sum !== 24'sd0 || bus.err_len !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b valid=%b data=%0d sum=%0d err=%b required all 0",
               bus.prod_ready, bus.out_valid, bus.out_data, bus.out_sum, bus.err_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: prod_ready=%b required 1", bus.prod_ready);
    end
  endtask

  task automatic test_saturation();
    run_window(9, 16129, 0, 24'sd0, 1'b1);
    take_result("sat_pos", 24'sd145161, 8'sd127, 1'b0);
    run_window(9, -16256, 0, 24'sd0, 1'b1);
    take_result("sat_neg", -24'sd146304, NEG_SAT, 1'b0);
  endtask

  task automatic test_rounding();
    run_window(9, 1, 1, 24'sd83, 1'b1);
    take_result("round_up", 24'sd128, 8'sd1, 1'b0);
    run_window(9, 1, 1, -24'sd83, 1'b1);
    take_result("round_neg", -24'sd38, 8'sd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_window(9, 1, 1, 24'sd83, 1'b1);
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = 16'sd1000;
    bus.prod_last  = 1'b1;
    bus.bias       = 24'sd0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.prod_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 24'sd128 ||
          bus.out_data !== 8'sd1 || bus.err_len !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: ready=%b valid=%b sum=%0d data=%0d err=%b required 0 1 128 1 0",
                 i, bus.prod_ready, bus.out_valid, bus.out_sum, bus.out_data, bus.err_len);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b ready=%b required 0 1", bus.out_valid, bus.prod_ready);
    end
    @(posedge clk);
    #1;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    take_result("after_stall", 24'sd1000, 8'sd8, 1'b1);
  endtask

  task automatic test_len_mismatch();
    run_window(4, 100, 0, 24'sd10, 1'b1);
    take_result("short_window", 24'sd410, 8'sd3, 1'b1);
    run_window(9, 1, 0, 24'sd0, 1'b0);
    take_result("long_window", 24'sd9, 8'sd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_window(5, 1000, 0, 24'sd500, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.prod_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b valid=%b required 0 0", bus.prod_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_window(9, 1, 0, 24'sd0, 1'b1);
    take_result("after_reset", 24'sd9, 8'sd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_len_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
